// File: rtl/mem_line_initiator.sv
// Cache-line bus initiator: one request becomes one memory transaction (BEATS-byte fill or line write-back).
// Define MEM_TIMEOUT_EN to add an ack watchdog that aborts with resp_err after TIMEOUT idle cycles.
module mem_line_initiator #(
  parameter int ADDR_W  = 16,
  parameter int BEATS   = 8,
  parameter int TIMEOUT = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic               req_rnw,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [8*BEATS-1:0] req_wline,
  output logic               req_ready,
  output logic               resp_valid,
  output logic [8*BEATS-1:0] resp_line,
  output logic               resp_err,
  output logic               mem_avalid,
  output logic               mem_rnw,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [8*BEATS-1:0] mem_wdata,
  input  logic               mem_ack,
  input  logic [7:0]         mem_rdata
);

  localparam int LINE_W = 8 * BEATS;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, RD_COLLECT, WR_WAIT, DONE} state_t;

  state_t              state_reg;
  logic [CNT_W-1:0]    beat_reg;
  logic                ready_reg;
  logic                valid_reg;
  logic [LINE_W-1:0]   line_reg;
  logic                avalid_reg;
  logic                rnw_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [LINE_W-1:0]   wdata_reg;

`ifdef MEM_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  logic [WD_W-1:0] wd_reg;
  logic            err_reg;
  assign resp_err = err_reg;
`else
  assign resp_err = 1'b0;
  // The watchdog length is meaningless without the watchdog.
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      beat_reg   <= '0;
      ready_reg  <= 1'b1;
      valid_reg  <= 1'b0;
      line_reg   <= '0;
      avalid_reg <= 1'b0;
      rnw_reg    <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
`ifdef MEM_TIMEOUT_EN
      wd_reg     <= '0;
      err_reg    <= 1'b0;
`endif
    end else begin
      // Strobes default low so each is high for exactly one cycle.
      avalid_reg <= 1'b0;
      valid_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            ready_reg  <= 1'b0;
            avalid_reg <= 1'b1;
            rnw_reg    <= req_rnw;
            addr_reg   <= req_addr;
            wdata_reg  <= req_wline;
            state_reg  <= ISSUE;
            if (req_rnw) begin
              beat_reg <= '0;
              line_reg <= '0;
            end
          end
        end
        ISSUE: begin
          state_reg <= rnw_reg ? RD_COLLECT : WR_WAIT;
`ifdef MEM_TIMEOUT_EN
          wd_reg    <= '0;
`endif
        end
        RD_COLLECT: begin
          if (mem_ack) begin
            for (int k = 0; k < BEATS; k++) begin
              if (beat_reg == CNT_W'(k)) line_reg[8*k +: 8] <= mem_rdata;
            end
            if (beat_reg == LAST_BEAT) begin
              state_reg <= DONE;
              valid_reg <= 1'b1;
            end else begin
              beat_reg <= beat_reg + 1'b1;
            end
          end
`ifdef MEM_TIMEOUT_EN
          if (mem_ack) begin
            wd_reg <= '0;
          end else if (wd_reg == WD_LAST) begin
            state_reg <= DONE;
            valid_reg <= 1'b1;
            err_reg   <= 1'b1;
          end else begin
            wd_reg <= wd_reg + 1'b1;
          end
`endif
        end
        WR_WAIT: begin
          if (mem_ack) begin
            state_reg <= DONE;
            valid_reg <= 1'b1;
          end
`ifdef MEM_TIMEOUT_EN
          else if (wd_reg == WD_LAST) begin
            state_reg <= DONE;
            valid_reg <= 1'b1;
            err_reg   <= 1'b1;
          end else begin
            wd_reg <= wd_reg + 1'b1;
          end
`endif
        end
        DONE: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
`ifdef MEM_TIMEOUT_EN
          err_reg   <= 1'b0;
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready  = ready_reg;
  assign resp_valid = valid_reg;
  assign resp_line  = line_reg;
  assign mem_avalid = avalid_reg;
  assign mem_rnw    = rnw_reg;
  assign mem_addr   = addr_reg;
  assign mem_wdata  = wdata_reg;

endmodule
